// File: rtl/fp_div_pkg.sv
// Shared divider-datapath definitions: default operand width, converter FSM states,
// and the most-negative-value helper.
package fp_div_pkg;

  localparam int unsigned DIV_WIDTH = 49;
  localparam int unsigned MAX_WIDTH = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_t;

  // Returns a word with only bit width-1 set; callers truncate to their own width.
  function automatic logic [MAX_WIDTH-1:0] most_neg(input int unsigned width);
    logic [MAX_WIDTH-1:0] v;
    v = '0;
    v[width-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/twos_to_signmag_seq_negate_chunk.sv
// Combinational CHUNK-bit invert-plus-carry-in slice used for ripple negation.
module negate_chunk #(
  parameter int unsigned CHUNK = 7
) (
  input  logic [CHUNK-1:0] i_x,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout
);

  logic [CHUNK:0] w_res;

  assign w_res  = {1'b0, ~i_x} + {{CHUNK{1'b0}}, i_cin};
  assign o_sum  = w_res[CHUNK-1:0];
  assign o_cout = w_res[CHUNK];

endmodule

// File: rtl/twos_to_signmag_seq.sv
// Multi-cycle two's-complement to sign-magnitude converter, negating CHUNK bits per cycle.
// Optional out_zero port enabled by defining TWOS_TO_SIGNMAG_ZERO_FLAG_EN.
module twos_to_signmag_seq
  import fp_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CHUNK = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-1:0] out_mag,
  output logic             out_ovf
`ifdef TWOS_TO_SIGNMAG_ZERO_FLAG_EN
  ,
  output logic             out_zero
`endif
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);
  localparam logic [MAX_WIDTH-1:0] MOST_NEG_FULL = most_neg(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = MOST_NEG_FULL[WIDTH-1:0];

  generate
    if ((WIDTH % CHUNK) != 0 || WIDTH > MAX_WIDTH || CHUNK == 0) begin : g_cfg_err
      $error("twos_to_signmag_seq: CHUNK must divide WIDTH and WIDTH must not exceed MAX_WIDTH");
    end
  endgenerate

  conv_state_t r_state, w_next;

  logic             r_sign;
  logic [WIDTH-1:0] r_mag;
  logic             r_ovf;
  logic             r_carry;
  logic [KW-1:0]    r_k;
  logic             w_accept;
  logic [CHUNK-1:0] w_chunk_in;
  logic [CHUNK-1:0] w_chunk_out;
  logic             w_cout;

  // The magnitude register holds the operand and is negated in place, one chunk per cycle.
  assign w_chunk_in = r_mag[r_k*CHUNK +: CHUNK];

  negate_chunk #(.CHUNK(CHUNK)) u_negate (
    .i_x   (w_chunk_in),
    .i_cin (r_carry),
    .o_sum (w_chunk_out),
    .o_cout(w_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_accept  = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = in_data[WIDTH-1] ? CONV : DONE;
        end
      end
      CONV: begin
        if (r_k == K_LAST) w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sign  <= 1'b0;
      r_mag   <= '0;
      r_ovf   <= 1'b0;
      r_carry <= 1'b0;
      r_k     <= '0;
    end else if (w_accept) begin
      r_sign  <= in_data[WIDTH-1];
      r_mag   <= in_data;
      r_ovf   <= (in_data == MOST_NEG);
      r_carry <= 1'b1;
      r_k     <= '0;
    end else if (r_state == CONV) begin
      // Carry out of the final chunk is only set for a negated zero, which never occurs.
      r_mag[r_k*CHUNK +: CHUNK] <= w_chunk_out;
      r_carry                   <= w_cout;
      r_k                       <= r_k + 1'b1;
    end
  end

  assign out_sign = r_sign;
  assign out_mag  = r_mag;
  assign out_ovf  = r_ovf;

`ifdef TWOS_TO_SIGNMAG_ZERO_FLAG_EN
  logic r_zero;

  always_ff @(posedge clk) begin
    if (rst)           r_zero <= 1'b0;
    else if (w_accept) r_zero <= (in_data == '0);
  end

  assign out_zero = r_zero;
`endif

endmodule

// File: tb/tb_twos_to_signmag_seq.sv
// Self-checking bench for twos_to_signmag_seq (WIDTH=49, CHUNK=7): vector table, random
// vectors, output stall and mid-conversion reset, with a scoreboard of expected results.
module tb_twos_to_signmag_seq;

  localparam int unsigned W = 49;

  typedef struct {
    logic [W-1:0] data;
    logic         sign;
    logic [W-1:0] mag;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic         sign;
    logic [W-1:0] mag;
    logic         ovf;
    logic         zero;
    int unsigned  lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_sign;
  logic [W-1:0] out_mag;
  logic         out_ovf;
`ifdef TWOS_TO_SIGNMAG_ZERO_FLAG_EN
  logic         out_zero;
`endif

  int checks   = 0;
  int failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  twos_to_signmag_seq #(.WIDTH(49), .CHUNK(7)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sign (out_sign),
    .out_mag  (out_mag),
    .out_ovf  (out_ovf)
`ifdef TWOS_TO_SIGNMAG_ZERO_FLAG_EN
    ,
    .out_zero (out_zero)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] d);
    exp_t e;
    e.sign = d[W-1];
    e.mag  = d[W-1] ? (~d + 49'd1) : d;
    e.ovf  = (d == {1'b1, {(W-1){1'b0}}});
    e.zero = (d == '0);
    e.lat  = d[W-1] ? 8 : 1;
    return e;
  endfunction

  // Drive one operand, wait for the result, compare against the scoreboard head, consume it.
  task automatic run_one(input logic [W-1:0] d, input exp_t e, input string tag);
    exp_t        h;
    int unsigned cyc;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    check({tag, ".in_ready_before"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = W'({$urandom, $urandom});
    sb.push_back(e);
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      if (in_ready) begin
        failures++;
        $display("FAIL %s.in_ready_busy: got 1 expected 0", tag);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    h = sb.pop_front();
    check({tag, ".latency"}, 64'(cyc), 64'(h.lat));
    check({tag, ".sign"}, 64'(out_sign), 64'(h.sign));
    check({tag, ".mag"}, 64'(out_mag), 64'(h.mag));
    check({tag, ".ovf"}, 64'(out_ovf), 64'(h.ovf));
`ifdef TWOS_TO_SIGNMAG_ZERO_FLAG_EN
    check({tag, ".zero"}, 64'(out_zero), 64'(h.zero));
`endif
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ".in_ready_after"}, 64'(in_ready), 64'd1);
    check({tag, ".out_valid_after"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    vec_t        tbl[8];
    exp_t        e;
    logic [W-1:0] d;
    logic        saw_valid;

    tbl[0] = '{49'd5,                 1'b0, 49'd5,                 1'b0};
    tbl[1] = '{{W{1'b1}},             1'b1, 49'd1,                 1'b0};
    tbl[2] = '{49'h1_FFFF_FFFF_FF80,  1'b1, 49'd128,               1'b0};
    tbl[3] = '{49'h1_0000_0000_0000,  1'b1, 49'h1_0000_0000_0000,  1'b1};
    tbl[4] = '{49'd0,                 1'b0, 49'd0,                 1'b0};
    tbl[5] = '{49'h0_FFFF_FFFF_FFFF,  1'b0, 49'h0_FFFF_FFFF_FFFF,  1'b0};
    tbl[6] = '{49'h1_0000_0000_0001,  1'b1, 49'h0_FFFF_FFFF_FFFF,  1'b0};
    tbl[7] = '{49'h1_FFFF_FFFF_C000,  1'b1, 49'h0_0000_0000_4000,  1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset.in_ready", 64'(in_ready), 64'd1);
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.out_sign", 64'(out_sign), 64'd0);
    check("reset.out_mag", 64'(out_mag), 64'd0);
    check("reset.out_ovf", 64'(out_ovf), 64'd0);

    for (int i = 0; i < 8; i++) begin
      e.sign = tbl[i].sign;
      e.mag  = tbl[i].mag;
      e.ovf  = tbl[i].ovf;
      e.zero = (tbl[i].data == '0);
      e.lat  = tbl[i].sign ? 8 : 1;
      run_one(tbl[i].data, e, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 6; i++) begin
      d = W'({$urandom, $urandom});
      d[W-1] = (i % 2 == 0);
      run_one(d, model(d), $sformatf("rnd%0d", i));
    end

    // Output stall: result must hold while out_ready is low.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 49'h1_FFFF_FFFF_FFFD;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int c = 0; c < 40 && !out_valid; c++) begin
      @(posedge clk);
      #1;
    end
    check("stall.out_valid", 64'(out_valid), 64'd1);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("stall%0d.mag", c), 64'(out_mag), 64'd3);
      check($sformatf("stall%0d.in_ready", c), 64'(in_ready), 64'd0);
      check($sformatf("stall%0d.valid", c), 64'(out_valid), 64'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("stall.in_ready_release", 64'(in_ready), 64'd1);

    // Reset during conversion discards the result.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = {W{1'b1}};
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sb.push_back(model({W{1'b1}}));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    check("rstconv.out_valid", 64'(out_valid), 64'd0);
    check("rstconv.out_sign", 64'(out_sign), 64'd0);
    check("rstconv.out_mag", 64'(out_mag), 64'd0);
    check("rstconv.out_ovf", 64'(out_ovf), 64'd0);
    check("rstconv.in_ready", 64'(in_ready), 64'd1);
    saw_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) saw_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    check("rstconv.no_output", 64'(saw_valid), 64'd0);
    check("rstconv.sb_empty", 64'(sb.size()), 64'd0);
    run_one(49'd7, model(49'd7), "post_rst7");
    run_one(49'd0, model(49'd0), "post_rst0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/twos_to_signmag_seq.md
Name: twos_to_signmag_seq

Overview:
- Multi-cycle converter from two's-complement to sign-magnitude form; the inverse direction of the divider's complement-2 negation units.
- Takes a signed WIDTH-bit value, such as a partial remainder or a quotient from the division datapath, and returns a sign bit plus an unsigned WIDTH-bit magnitude.
- Negative inputs are negated CHUNK bits per cycle, rippling the carry between cycles so long carry chains stay short for timing.
- Sits between the divider core and the normalise/round stage, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 49: operand width in bits; bit WIDTH-1 is the sign.
- CHUNK, 7: bits negated per cycle; must divide WIDTH exactly (elaboration-time check).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept an input.
- in_data  input  WIDTH  two's-complement operand.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_sign  output  1  sign of the operand (1 = negative).
- out_mag  output  WIDTH  unsigned magnitude.
- out_ovf  output  1  magnitude needs WIDTH bits (input was the most-negative value).

Behaviour:
- Derived constant: NCHUNK = WIDTH/CHUNK.
- States:
  - IDLE: in_ready=1.
  - CONV: negating, chunk index k = 0..NCHUNK-1.
  - DONE: out_valid=1.
- Reset values (on rst, whatever the state): state=IDLE, in_ready=1, out_valid=0, out_sign=0, out_mag=0, out_ovf=0, carry=0, k=0. Any conversion in flight is discarded, and no output is produced for it.
- Input accept: the handshake completes when in_valid and in_ready are both high in IDLE. The block latches in_data and sets sign = in_data[WIDTH-1].
- Positive or zero input (sign=0):
  - Next state is DONE, with out_mag = in_data and out_ovf=0.
  - out_valid rises in the cycle after accept (latency 1).
- Negative input (sign=1):
  - Next state is CONV, with carry=1 and k=0.
  - Each CONV cycle computes chunk k as ~x[k*CHUNK +: CHUNK] + carry, writes it into the magnitude register, stores the chunk carry-out as the new carry, and increments k. The LSB chunk goes first.
  - After chunk NCHUNK-1 the block moves to DONE.
  - out_valid rises NCHUNK+1 cycles after accept (8 for the defaults).
- Overflow: out_ovf=1 only when the input is 1 followed by WIDTH-1 zeros. In that case out_mag = 1 followed by WIDTH-1 zeros, which is the correct unsigned value. Otherwise out_ovf=0.
- DONE:
  - out_sign, out_mag and out_ovf are registered and held stable while out_valid=1 and out_ready=0.
  - When out_ready=1 the result is consumed and the next state is IDLE; in_ready=1 in the following cycle.
  - No same-cycle pass-through: the minimum spacing between accepts is 2 cycles for positive inputs and NCHUNK+2 cycles for negative inputs.
- in_ready is low in CONV and DONE, and in_data is ignored there.
- in_valid asserted during rst has no effect. It is accepted on the first IDLE cycle after rst deasserts.
- Final carry-out: it is nonzero only for input 0 treated as negative, which cannot occur, so it is discarded.

Optional Feature:
- TWOS_TO_SIGNMAG_ZERO_FLAG_EN.
- Defined: adds output port out_zero (1 bit, reset 0), registered and valid with out_valid. It is 1 iff out_mag == 0 and is detected at accept time from in_data == 0. Downstream uses it for exact-result and sticky handling.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package fp_div_pkg holds:
  - the default width constant (49);
  - the state enum type, IDLE/CONV/DONE;
  - the most-negative-value constant function of WIDTH.
- One natural sub-module: negate_chunk, a combinational CHUNK-bit invert-plus-carry-in unit with carry-out, instantiated once and reused every cycle.

Test Plan (WIDTH=49, CHUNK=7):
- in_data=5, out_ready=1 → out_valid 1 cycle after accept; sign=0, mag=5, ovf=0.
- in_data=all ones (-1) → out_valid 8 cycles after accept; sign=1, mag=1, ovf=0.
- in_data=-128 (low 7 bits zero, carry must cross the chunk 0→1 boundary) → sign=1, mag=128.
- in_data=0x1_0000_0000_0000 (bit 48 only) → sign=1, mag=0x1_0000_0000_0000, ovf=1.
- in_data=-3, out_ready held 0 for 5 cycles after out_valid → out_mag=3 stays stable and in_ready stays 0; in_ready=1 the cycle after out_ready=1.
- in_data=-1 accepted, rst pulsed at CONV cycle 3 → out_valid stays 0 and outputs are 0. The next accept of in_data=7 yields mag=7 after 1 cycle; with TWOS_TO_SIGNMAG_ZERO_FLAG_EN defined, in_data=0 gives out_zero=1.
